// File: rtl/spio_spinnaker_link_sender_pipe.sv
// ============================================================================
// Module   : spio_spinnaker_link_sender_pipe
// Purpose  : Single-buffered SpiNNaker-link packet sender with NRZ 2-of-7
//            symbol encoding and 4-phase ack handshaking.
// Options  : `define SPIO_SL_SENDER_TIMEOUT_EN adds the ack-timeout counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spio_spinnaker_link_sender_pipe #(
   parameter int PKT_BITS  = 72,
   parameter int TO_BITS   = 16,
   parameter int TO_CYCLES = 4095
) (
   input  logic                CLK_IN,
   input  logic                RESET_IN,
   input  logic [PKT_BITS-1:0] PKT_DATA_IN,
   input  logic                PKT_VLD_IN,
   output logic                PKT_RDY_OUT,
   output logic [6:0]          SL_DATA_2OF7_OUT,
   input  logic                SL_ACK_IN,
   output logic                PKT_SENT_OUT,
   output logic                BUSY_OUT,
   output logic                ERR_TO_OUT,
   input  logic                ERR_CLR_IN
);

   localparam int                CNT_W        = $clog2(PKT_BITS / 4);
   localparam logic [CNT_W-1:0]  C_SHORT_LAST = CNT_W'(9);
   localparam logic [CNT_W-1:0]  C_LONG_LAST  = CNT_W'(PKT_BITS / 4 - 1);
   localparam logic [6:0]        C_EOP_CODE   = 7'b1100000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_TRAN = 2'd1,
      ST_EOP  = 2'd2
   } state_t;

   function automatic logic [6:0] f_code(input logic [3:0] n);
      logic [6:0] c;
      case (n)
         4'd0:    c = 7'b0010001;
         4'd1:    c = 7'b0010010;
         4'd2:    c = 7'b0010100;
         4'd3:    c = 7'b0011000;
         4'd4:    c = 7'b0100001;
         4'd5:    c = 7'b0100010;
         4'd6:    c = 7'b0100100;
         4'd7:    c = 7'b0101000;
         4'd8:    c = 7'b1000001;
         4'd9:    c = 7'b1000010;
         4'd10:   c = 7'b1000100;
         4'd11:   c = 7'b1001000;
         4'd12:   c = 7'b0000011;
         4'd13:   c = 7'b0000110;
         4'd14:   c = 7'b0001100;
         default: c = 7'b0001001;
      endcase
      return c;
   endfunction

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_ack_s1;
   logic                r_ack_s2;
   logic                r_old_ack;
   logic                w_old_ack_nxt;
   logic                w_ack_edge;
   logic [PKT_BITS-1:0] r_buf;
   logic                r_buf_vld;
   logic                w_xfer;
   logic                w_load;
   logic [PKT_BITS-1:0] r_shift;
   logic [PKT_BITS-1:0] w_shift_nxt;
   logic [CNT_W-1:0]    r_cnt;
   logic [CNT_W-1:0]    w_cnt_nxt;
   logic [6:0]          r_data;
   logic [6:0]          w_data_nxt;
   logic                r_sent;
   logic                w_sent_nxt;
   logic                w_sym_drv;

   assign w_ack_edge       = (r_ack_s2 != r_old_ack);
   assign w_xfer           = PKT_VLD_IN && !r_buf_vld;
   assign PKT_RDY_OUT      = !r_buf_vld;
   assign SL_DATA_2OF7_OUT = r_data;
   assign PKT_SENT_OUT     = r_sent;
   assign BUSY_OUT         = (r_state != ST_IDLE);

   always_ff @(posedge CLK_IN or posedge RESET_IN) begin
      if (RESET_IN) begin
         r_ack_s1 <= 1'b0;
         r_ack_s2 <= 1'b0;
      end else begin
         r_ack_s1 <= SL_ACK_IN;
         r_ack_s2 <= r_ack_s1;
      end
   end

   always_ff @(posedge CLK_IN or posedge RESET_IN) begin
      if (RESET_IN) begin
         r_buf     <= '0;
         r_buf_vld <= 1'b0;
      end else if (w_load) begin
         r_buf_vld <= 1'b0;
      end else if (w_xfer) begin
         r_buf     <= PKT_DATA_IN;
         r_buf_vld <= 1'b1;
      end
   end

   always_ff @(posedge CLK_IN or posedge RESET_IN) begin
      if (RESET_IN) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Every symbol change is an XOR with a 2-hot code, so the NRZ output
   // always moves by exactly two wires per symbol.
   always_comb begin
      w_state_nxt   = r_state;
      w_data_nxt    = r_data;
      w_shift_nxt   = r_shift;
      w_cnt_nxt     = r_cnt;
      w_old_ack_nxt = r_old_ack;
      w_sent_nxt    = 1'b0;
      w_sym_drv     = 1'b0;
      w_load        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (r_buf_vld) begin
               w_load = 1'b1;
            end
         end
         ST_TRAN: begin
            if (w_ack_edge) begin
               w_old_ack_nxt = r_ack_s2;
               w_sym_drv     = 1'b1;
               if (r_cnt != '0) begin
                  w_data_nxt  = r_data ^ f_code(r_shift[3:0]);
                  w_shift_nxt = r_shift >> 4;
                  w_cnt_nxt   = r_cnt - CNT_W'(1);
               end else begin
                  w_data_nxt  = r_data ^ C_EOP_CODE;
                  w_state_nxt = ST_EOP;
               end
            end
         end
         ST_EOP: begin
            if (w_ack_edge) begin
               w_old_ack_nxt = r_ack_s2;
               w_sent_nxt    = 1'b1;
               if (r_buf_vld) begin
                  w_load = 1'b1;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
      // Loading emits symbol 0 straight from the buffer; the shifter keeps
      // the remaining nibbles and the counter the remaining data symbols.
      if (w_load) begin
         w_data_nxt    = r_data ^ f_code(r_buf[3:0]);
         w_shift_nxt   = r_buf >> 4;
         w_cnt_nxt     = r_buf[1] ? C_LONG_LAST : C_SHORT_LAST;
         w_old_ack_nxt = r_ack_s2;
         w_sym_drv     = 1'b1;
         w_state_nxt   = ST_TRAN;
      end
   end

   always_ff @(posedge CLK_IN or posedge RESET_IN) begin
      if (RESET_IN) begin
         r_data    <= '0;
         r_shift   <= '0;
         r_cnt     <= '0;
         r_old_ack <= 1'b0;
         r_sent    <= 1'b0;
      end else begin
         r_data    <= w_data_nxt;
         r_shift   <= w_shift_nxt;
         r_cnt     <= w_cnt_nxt;
         r_old_ack <= w_old_ack_nxt;
         r_sent    <= w_sent_nxt;
      end
   end

`ifdef SPIO_SL_SENDER_TIMEOUT_EN
   localparam logic [TO_BITS-1:0] C_TO_LIMIT = TO_BITS'(TO_CYCLES);

   logic [TO_BITS-1:0] r_to_cnt;
   logic               r_err_to;

   // Timeout only reports; the link keeps waiting for the ack indefinitely.
   always_ff @(posedge CLK_IN or posedge RESET_IN) begin
      if (RESET_IN) begin
         r_to_cnt <= '0;
         r_err_to <= 1'b0;
      end else begin
         if (w_sym_drv) begin
            r_to_cnt <= '0;
         end else if ((r_state != ST_IDLE) && !w_ack_edge && (r_to_cnt != {TO_BITS{1'b1}})) begin
            r_to_cnt <= r_to_cnt + TO_BITS'(1);
         end
         if (ERR_CLR_IN) begin
            r_err_to <= 1'b0;
         end else if ((r_state != ST_IDLE) && (r_to_cnt == C_TO_LIMIT)) begin
            r_err_to <= 1'b1;
         end
      end
   end

   assign ERR_TO_OUT = r_err_to;
`else
   logic               w_unused_err_clr;
   logic [TO_BITS-1:0] w_unused_to_limit;

   assign w_unused_err_clr  = ERR_CLR_IN;
   assign w_unused_to_limit = TO_BITS'(TO_CYCLES);
   assign ERR_TO_OUT        = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_spio_spinnaker_link_sender_pipe.sv
// ============================================================================
// Module   : tb_spio_spinnaker_link_sender_pipe
// Purpose  : Directed self-checking bench with an ack-toggling link responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_spio_spinnaker_link_sender_pipe;

   localparam int PKT_BITS = 72;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic [PKT_BITS-1:0] pkt = '0;
   logic                vld = 1'b0;
   logic                rdy;
   logic [6:0]          dout;
   logic                ack = 1'b0;
   logic                sent;
   logic                busy;
   logic                err;
   logic                err_clr = 1'b0;

   always #5 clk = ~clk;

   spio_spinnaker_link_sender_pipe #(
      .PKT_BITS  (PKT_BITS),
      .TO_BITS   (16),
      .TO_CYCLES (20)
   ) u_dut (
      .CLK_IN           (clk),
      .RESET_IN         (rst),
      .PKT_DATA_IN      (pkt),
      .PKT_VLD_IN       (vld),
      .PKT_RDY_OUT      (rdy),
      .SL_DATA_2OF7_OUT (dout),
      .SL_ACK_IN        (ack),
      .PKT_SENT_OUT     (sent),
      .BUSY_OUT         (busy),
      .ERR_TO_OUT       (err),
      .ERR_CLR_IN       (err_clr)
   );

`ifdef SPIO_SL_SENDER_TIMEOUT_EN
   localparam logic c_err_exp = 1'b1;
`else
   localparam logic c_err_exp = 1'b0;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_val(input string tag, input logic [71:0] act, input logic [71:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic int sym_decode(input logic [6:0] d);
      case (d)
         7'h11: return 0;   7'h12: return 1;   7'h14: return 2;   7'h18: return 3;
         7'h21: return 4;   7'h22: return 5;   7'h24: return 6;   7'h28: return 7;
         7'h41: return 8;   7'h42: return 9;   7'h44: return 10;  7'h48: return 11;
         7'h03: return 12;  7'h06: return 13;  7'h0C: return 14;  7'h09: return 15;
         7'h60: return 16;
         default: return 31;
      endcase
   endfunction

   // Link responder: logs each symbol, then toggles ack two cycles later
   int         q_sym[$];
   bit         q_snt[$];
   int         bad_trans = 0;
   int         sent_cnt  = 0;
   int         busy_drop = 0;
   int         ack_due   = 0;
   int         stall_at  = 0;
   int         mon_limit = 0;
   bit         mon_busy  = 1'b0;
   logic [6:0] prev      = '0;

   always @(negedge clk) begin
      if (rst) begin
         prev    = '0;
         ack_due = 0;
      end else begin
         if (sent) sent_cnt++;
         if (mon_busy && sent_cnt < mon_limit && !busy) busy_drop++;
         if (dout !== prev) begin
            if ($countones(dout ^ prev) != 2) bad_trans++;
            q_sym.push_back(sym_decode(dout ^ prev));
            q_snt.push_back(sent);
            prev    = dout;
            ack_due = 2;
         end else if (ack_due > 0 && !(stall_at > 0 && q_sym.size() >= stall_at)) begin
            ack_due--;
            if (ack_due == 0) ack = ~ack;
         end
      end
   end

   int exp_q[$];

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input logic [PKT_BITS-1:0] d);
      int n;
      n = 0;
      while (!rdy && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check_val("push_rdy", {71'd0, rdy}, 72'd1);
      pkt = d;
      vld = 1'b1;
      @(negedge clk);
      vld = 1'b0;
   endtask

   task automatic wait_sent(input string tag, input int target);
      int n;
      n = 0;
      while (sent_cnt < target && n < 3000) begin
         @(negedge clk);
         n++;
      end
      wait_cycles(10);
      check_val({tag, "_sent"}, sent_cnt, target);
      check_val({tag, "_busy_end"}, {71'd0, busy}, 72'd0);
   endtask

   task automatic build_exp(input logic [PKT_BITS-1:0] d);
      int ns;
      logic [PKT_BITS-1:0] v;
      v  = d;
      ns = v[1] ? PKT_BITS / 4 : 10;
      for (int i = 0; i < ns; i++) exp_q.push_back(int'(v[4*i +: 4]));
      exp_q.push_back(16);
   endtask

   task automatic check_seq(input string tag, input int base);
      check_val({tag, "_len"}, q_sym.size() - base, exp_q.size());
      for (int i = 0; i < exp_q.size() && base + i < q_sym.size(); i++)
         check_val($sformatf("%s_sym%0d", tag, i), q_sym[base + i], exp_q[i]);
   endtask

   initial begin
      int base;
      int sbase;
      int dbase;
      int s0;
      int n;
      logic [6:0] hold;
      logic [PKT_BITS-1:0] pa;
      logic [PKT_BITS-1:0] pb;

      // Reset state
      wait_cycles(3);
      check_val("rst_data", dout, 7'h00);
      check_val("rst_rdy",  {71'd0, rdy},  72'd1);
      check_val("rst_busy", {71'd0, busy}, 72'd0);
      check_val("rst_err",  {71'd0, err},  72'd0);
      check_val("rst_sent", {71'd0, sent}, 72'd0);
      rst = 1'b0;
      wait_cycles(5);
      check_val("post_rst_data", dout, 7'h00);

      // Short packet, plus symbol-0 latency
      base  = q_sym.size();
      sbase = sent_cnt;
      push(72'h00_1234_5670);
      check_val("lat_busy0", {71'd0, busy}, 72'd0);
      check_val("lat_rdy0",  {71'd0, rdy},  72'd0);
      check_val("lat_data0", dout, 7'h00);
      @(negedge clk);
      check_val("lat_busy1", {71'd0, busy}, 72'd1);
      check_val("lat_data1", dout, 7'h11);
      wait_sent("short", sbase + 1);
      exp_q = '{0, 7, 6, 5, 4, 3, 2, 1, 0, 0, 16};
      check_seq("short", base);
      check_val("short_2bit", bad_trans, 0);

      // Two long packets back-to-back
      pa = 72'h12_3456_789A_BCDE_F012;
      pb = 72'hFE_DCBA_9876_5432_10AB;
      base      = q_sym.size();
      sbase     = sent_cnt;
      dbase     = busy_drop;
      mon_limit = sbase + 2;
      push(pa);
      push(pb);
      mon_busy = 1'b1;
      wait_sent("b2b", sbase + 2);
      mon_busy = 1'b0;
      exp_q = {};
      build_exp(pa);
      build_exp(pb);
      check_seq("b2b", base);
      if (q_sym.size() > base + 19)
         check_val("b2b_zero_gap", {71'd0, q_snt[base + 19]}, 72'd1);
      else
         check_val("b2b_zero_gap_missing", q_sym.size() - base, 72'd38);
      check_val("b2b_busy_hold", busy_drop - dbase, 0);
      check_val("b2b_2bit", bad_trans, 0);

      // Ack stall after the third symbol
      base     = q_sym.size();
      sbase    = sent_cnt;
      stall_at = base + 3;
      push(72'h00_89AB_CDEC);
      n = 0;
      while (q_sym.size() < base + 3 && n < 500) begin
         @(negedge clk);
         n++;
      end
      hold = dout;
      wait_cycles(10);
      check_val("stall_err_early", {71'd0, err}, 72'd0);
      wait_cycles(30);
      check_val("stall_hold_data", dout, hold);
      check_val("stall_hold_len", q_sym.size() - base, 3);
      check_val("stall_err", {71'd0, err}, {71'd0, c_err_exp});
      stall_at = 0;
      wait_sent("stall", sbase + 1);
      exp_q = '{12, 14, 13, 12, 11, 10, 9, 8, 0, 0, 16};
      check_seq("stall", base);
      check_val("stall_err_sticky", {71'd0, err}, {71'd0, c_err_exp});
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      check_val("stall_err_clr", {71'd0, err}, 72'd0);

      // Reset mid-packet with a buffered packet
      base = q_sym.size();
      push(pa);
      push(pb);
      n = 0;
      while (q_sym.size() < base + 5 && n < 500) begin
         @(negedge clk);
         n++;
      end
      check_val("mid_reached", {71'd0, busy}, 72'd1);
      rst = 1'b1;
      @(negedge clk);
      check_val("mid_rst_data", dout, 7'h00);
      check_val("mid_rst_rdy",  {71'd0, rdy},  72'd1);
      check_val("mid_rst_busy", {71'd0, busy}, 72'd0);
      check_val("mid_rst_err",  {71'd0, err},  72'd0);
      check_val("mid_rst_sent", {71'd0, sent}, 72'd0);
      s0  = q_sym.size();
      rst = 1'b0;
      wait_cycles(20);
      check_val("mid_quiet_len",  q_sym.size(), s0);
      check_val("mid_quiet_data", dout, 7'h00);
      check_val("mid_quiet_busy", {71'd0, busy}, 72'd0);
      base  = q_sym.size();
      sbase = sent_cnt;
      push(72'h00_1234_5670);
      wait_sent("after_rst", sbase + 1);
      exp_q = '{0, 7, 6, 5, 4, 3, 2, 1, 0, 0, 16};
      check_seq("after_rst", base);
      check_val("final_2bit", bad_trans, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/spio_spinnaker_link_sender_pipe.md
SPIO_SPINNAKER_LINK_SENDER_PIPE -- requirements
Module: spio_spinnaker_link_sender_pipe

Interface
REQ-001 SHALL have parameter PKT_BITS, default 72, meaning packet width in bits; legal values are multiples of 4, at least 40.
REQ-002 SHALL have parameter TO_BITS, default 16, meaning ack-timeout counter width.
REQ-003 SHALL have parameter TO_CYCLES, default 4095, meaning cycles without an ack edge before timeout; must be < 2^TO_BITS.
REQ-004 CLK_IN  input  1  clock.
REQ-005 RESET_IN  input  1  reset: asynchronous, active-high.
REQ-006 PKT_DATA_IN  input  PKT_BITS  packet; bit 1 = long flag.
REQ-007 PKT_VLD_IN  input  1  packet valid.
REQ-008 PKT_RDY_OUT  output  1  holding buffer empty.
REQ-009 SL_DATA_2OF7_OUT  output  7  NRZ 2-of-7 link data.
REQ-010 SL_ACK_IN  input  1  asynchronous link ack (NRZ toggle).
REQ-011 PKT_SENT_OUT  output  1  one-cycle pulse when the EOP symbol is acknowledged.
REQ-012 BUSY_OUT  output  1  high when state is not IDLE.
REQ-013 ERR_TO_OUT  output  1  sticky ack-timeout flag.
REQ-014 ERR_CLR_IN  input  1  clears ERR_TO_OUT.

Function
REQ-015 SHALL pass SL_ACK_IN through a 2-flop synchroniser; an ack edge is when the synchronised ack differs from the stored old_ack.
REQ-016 SHALL hold one packet in a holding buffer; PKT_RDY_OUT = !buf_vld; a transfer occurs when PKT_VLD_IN and PKT_RDY_OUT are both high at a rising edge.
REQ-017 SHALL encode symbol n by XOR of SL_DATA_2OF7_OUT with the following codes: 0:0010001, 1:0010010, 2:0010100, 3:0011000, 4:0100001, 5:0100010, 6:0100100, 7:0101000, 8:1000001, 9:1000010, 10:1000100, 11:1001000, 12:0000011, 13:0000110, 14:0001100, 15:0001001, EOP:1100000.
REQ-018 SHALL send nibbles LSB first.
REQ-019 Symbol count: short packets (bit1=0) SHALL send 10 data symbols; long packets SHALL send PKT_BITS/4 data symbols; each packet SHALL be followed by one EOP symbol.
REQ-020 SHALL implement states IDLE, TRAN and EOP.
REQ-021 IDLE with buf_vld: load the shifter, drive symbol 0, store the current ack in old_ack, clear buf_vld, go to TRAN.
REQ-022 Latency: symbol 0 SHALL appear on the edge after the buffer becomes valid, i.e. 2 edges after the transfer when idle.
REQ-023 TRAN, on each ack edge: drive the next data symbol, or drive EOP after the last data symbol and go to EOP; without an ack edge, hold all values.
REQ-024 EOP, on ack edge: pulse PKT_SENT_OUT; if buf_vld, drive symbol 0 of the buffered packet in the same cycle and go to TRAN (zero-gap back-to-back); otherwise go to IDLE.
REQ-025 A new transfer into the buffer SHALL be accepted in any state while the buffer is empty.
REQ-026 SL_DATA_2OF7_OUT SHALL change only in the cycles named in REQ-021 to REQ-024, and each change SHALL differ from the previous value in exactly 2 bits.

Reset
REQ-027 Under RESET_IN, SHALL force: state IDLE, SL_DATA_2OF7_OUT 0, synchroniser and old_ack 0, buf_vld 0 (PKT_RDY_OUT 1), PKT_SENT_OUT 0, BUSY_OUT 0, ERR_TO_OUT 0, timeout counter 0.
REQ-028 Reset mid-packet SHALL abandon the packet and any buffered packet; after release no symbol SHALL be driven until a new transfer occurs.

Configuration
REQ-029 Macro SPIO_SL_SENDER_TIMEOUT_EN defined: the counter SHALL clear on every symbol driven and increment each cycle in TRAN/EOP without an ack edge, saturating.
REQ-030 With the macro defined, reaching TO_CYCLES SHALL set ERR_TO_OUT; ERR_CLR_IN SHALL clear it, and clear has priority over set; the transmission keeps waiting and is never aborted.
REQ-031 Macro undefined: no counter SHALL be present, ERR_TO_OUT SHALL be tied 0 and ERR_CLR_IN SHALL be ignored.

Verification
REQ-032 Reset assert/release -> SL_DATA_2OF7_OUT=0, PKT_RDY_OUT=1, BUSY_OUT=0, ERR_TO_OUT=0.
REQ-033 Short packet 0x00_1234_5670 sent with an ack-toggling responder -> 11 two-bit transitions decoding to 0,7,6,5,4,3,2,1,0,0 then EOP; one PKT_SENT_OUT pulse.
REQ-034 Two long packets (bit1=1) presented back-to-back -> 19 symbols each; symbol 0 of packet 2 on the same edge as the ack of packet 1's EOP; BUSY_OUT stays high throughout.
REQ-035 Ack held after the 3rd symbol, macro defined, TO_CYCLES=20 -> ERR_TO_OUT rises after 20 stalled cycles; data holds; on ack resume, transmission completes; ERR_CLR_IN clears the flag.
REQ-036 RESET_IN pulsed mid-TRAN with a buffered packet -> REQ-027 values; the next packet transmits correctly from symbol 0.
REQ-037 Same as REQ-035 with the macro undefined -> ERR_TO_OUT stays 0.
